// File: rtl/data_table_rd_arbiter.sv
// Round-robin arbiter for the shared data-table RAM read port.
// Tracks each read through the RAM latency and returns the data-valid strobe to its requester.
module data_table_rd_arbiter #(
  parameter int unsigned ENGINES_CNT     = 3,
  parameter int unsigned RAM_LATENCY     = 2,
  parameter int unsigned A_WIDTH         = 12,
  parameter int unsigned D_WIDTH         = 64,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ENGINES_CNT*A_WIDTH-1:0] req_addr_i,
  input  logic [ENGINES_CNT-1:0]         req_valid_i,
  output logic [ENGINES_CNT-1:0]         req_ready_o,
  output logic [A_WIDTH-1:0]             rd_addr_o,
  output logic                           rd_en_o,
  input  logic [D_WIDTH-1:0]             rd_data_i,
  output logic [D_WIDTH-1:0]             rd_data_o,
  output logic [ENGINES_CNT-1:0]         rd_data_val_o,
  output logic                           busy_o
);

  localparam int unsigned IDX_W = $clog2(ENGINES_CNT);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SUM_W = IDX_W + 1;

  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       out_cnt_q [ENGINES_CNT];
  logic [CNT_W-1:0]       out_cnt_d [ENGINES_CNT];
  logic [RAM_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [IDX_W-1:0]       tag_idx_q [RAM_LATENCY];
  logic [IDX_W-1:0]       tag_idx_d [RAM_LATENCY];
  logic                   busy_q, busy_d;

  logic [A_WIDTH-1:0]     addr_arr [ENGINES_CNT];
  logic [ENGINES_CNT-1:0] eligible;
  logic [IDX_W-1:0]       winner;
  logic                   grant;
  logic [SUM_W-1:0]       scan_sum;
  logic [IDX_W-1:0]       scan_idx;

  for (genvar g = 0; g < int'(ENGINES_CNT); g++) begin : g_addr
    assign addr_arr[g] = req_addr_i[g*A_WIDTH +: A_WIDTH];
  end

  // Data-valid strobe at tag exit; reads caught by a reset are dropped
  always_comb begin
    rd_data_val_o = '0;
    if (tag_vld_q[RAM_LATENCY-1] && !rst_i) begin
      rd_data_val_o[tag_idx_q[RAM_LATENCY-1]] = 1'b1;
    end
  end

  assign rd_data_o = rd_data_i;
  assign busy_o    = busy_q;

  // A read returning this cycle frees its slot for a grant in the same cycle
  always_comb begin
    eligible = '0;
    for (int i = 0; i < int'(ENGINES_CNT); i++) begin
      eligible[i] = req_valid_i[i] &
                    ((out_cnt_q[i] - CNT_W'(rd_data_val_o[i])) != CNT_W'(MAX_OUTSTANDING));
    end
  end

  // Round-robin scan starting at rr_ptr
  always_comb begin
    grant    = 1'b0;
    winner   = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < int'(ENGINES_CNT); k++) begin
      scan_sum = {1'b0, rr_ptr_q} + SUM_W'(k);
      if (scan_sum >= SUM_W'(ENGINES_CNT)) begin
        scan_sum = scan_sum - SUM_W'(ENGINES_CNT);
      end
      scan_idx = IDX_W'(scan_sum);
      if (!grant && eligible[scan_idx]) begin
        grant  = 1'b1;
        winner = scan_idx;
      end
    end
    if (rst_i) begin
      grant = 1'b0;
    end
  end

  always_comb begin
    req_ready_o = '0;
    rd_addr_o   = '0;
    if (grant) begin
      req_ready_o[winner] = 1'b1;
      rd_addr_o           = addr_arr[winner];
    end
  end

  assign rd_en_o = grant;

  // Next state: pointer, tag pipeline, outstanding counters
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (winner == IDX_W'(ENGINES_CNT - 1)) ? '0 : winner + IDX_W'(1);
    end

    tag_vld_d    = '0;
    tag_vld_d[0] = grant;
    tag_idx_d[0] = winner;
    for (int s = 1; s < int'(RAM_LATENCY); s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end

    busy_d = 1'b0;
    for (int i = 0; i < int'(ENGINES_CNT); i++) begin
      out_cnt_d[i] = out_cnt_q[i];
      if ((grant && (winner == IDX_W'(i))) && !rd_data_val_o[i]) begin
        out_cnt_d[i] = out_cnt_q[i] + CNT_W'(1);
      end else if (!(grant && (winner == IDX_W'(i))) && rd_data_val_o[i]) begin
        out_cnt_d[i] = out_cnt_q[i] - CNT_W'(1);
      end
      busy_d = busy_d | (out_cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q  <= '0;
      tag_vld_q <= '0;
      busy_q    <= 1'b0;
      for (int s = 0; s < int'(RAM_LATENCY); s++) begin
        tag_idx_q[s] <= '0;
      end
      for (int i = 0; i < int'(ENGINES_CNT); i++) begin
        out_cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      tag_vld_q <= tag_vld_d;
      busy_q    <= busy_d;
      for (int s = 0; s < int'(RAM_LATENCY); s++) begin
        tag_idx_q[s] <= tag_idx_d[s];
      end
      for (int i = 0; i < int'(ENGINES_CNT); i++) begin
        out_cnt_q[i] <= out_cnt_d[i];
      end
    end
  end

  // Counter bounds and busy/tag-pipeline consistency
  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(ENGINES_CNT); i++) begin
        assert (out_cnt_q[i] <= CNT_W'(MAX_OUTSTANDING))
          else $error("out_cnt[%0d] above cap", i);
        assert (!(rd_data_val_o[i] && (out_cnt_q[i] == '0)))
          else $error("out_cnt[%0d] underflow", i);
      end
      assert (busy_q == (|tag_vld_q))
        else $error("busy does not match tag pipeline");
    end
  end

endmodule

// File: tb/tb_data_table_rd_arbiter.sv
// Bench for data_table_rd_arbiter: directed scenarios then random traffic against a queue-based model.
module tb_data_table_rd_arbiter;

  localparam int unsigned E    = 3;
  localparam int unsigned L    = 2;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 16;
  localparam int unsigned MAXO = 1;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [E*AW-1:0] req_addr_i;
  logic [E-1:0]    req_valid_i;
  logic [E-1:0]    req_ready_o;
  logic [AW-1:0]   rd_addr_o;
  logic            rd_en_o;
  logic [DW-1:0]   rd_data_i;
  logic [DW-1:0]   rd_data_o;
  logic [E-1:0]    rd_data_val_o;
  logic            busy_o;

  always #5 clk = ~clk;

  data_table_rd_arbiter #(
    .ENGINES_CNT(E), .RAM_LATENCY(L), .A_WIDTH(AW), .D_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_addr_i(req_addr_i), .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o), .rd_addr_o(rd_addr_o), .rd_en_o(rd_en_o),
    .rd_data_i(rd_data_i), .rd_data_o(rd_data_o), .rd_data_val_o(rd_data_val_o),
    .busy_o(busy_o)
  );

  // RAM model: data = addr + 0x100, L cycles after the read
  logic [AW-1:0] ram_addr [L];
  always @(posedge clk) begin
    for (int s = int'(L) - 1; s > 0; s--) ram_addr[s] <= ram_addr[s-1];
    ram_addr[0] <= rd_addr_o;
  end
  assign rd_data_i = DW'(ram_addr[L-1]) + DW'(16'h100);

  typedef struct {
    int            eng;
    int            due;
    logic [AW-1:0] addr;
  } rec_t;

  rec_t q[$];
  int   rr     = 0;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive, compare against model, advance model at the edge
  task automatic step(input logic r, input logic [E-1:0] v, input logic [E*AW-1:0] a,
                      input logic use_want, input logic [E-1:0] want);
    logic [E-1:0]  exp_rdy, exp_val;
    logic          exp_busy;
    logic [AW-1:0] exp_addr, g_addr;
    logic [DW-1:0] exp_data;
    int            w;
    int            pend [E];
    rec_t          keep [$];
    rst_i = r; req_valid_i = v; req_addr_i = a;
    #2;
    exp_busy = (q.size() != 0);
    exp_rdy  = '0; exp_val = '0; exp_addr = '0; exp_data = '0; w = -1;
    for (int i = 0; i < int'(E); i++) pend[i] = 0;
    if (!r) begin
      foreach (q[n]) begin
        if (q[n].due == cyc) begin
          exp_val[q[n].eng] = 1'b1;
          exp_data = DW'(q[n].addr) + DW'(16'h100);
        end else begin
          pend[q[n].eng]++;
        end
      end
      for (int k = 0; k < int'(E); k++) begin
        int j;
        j = (rr + k) % int'(E);
        if (w < 0 && v[j] && pend[j] < int'(MAXO)) w = j;
      end
      if (w >= 0) begin
        exp_rdy[w] = 1'b1;
        exp_addr   = a[w*int'(AW) +: AW];
      end
    end
    chk("req_ready", 32'(req_ready_o), 32'(exp_rdy));
    chk("rd_en", 32'(rd_en_o), 32'(exp_rdy != '0));
    chk("rd_addr", 32'(rd_addr_o), 32'(exp_addr));
    chk("rd_data_val", 32'(rd_data_val_o), 32'(exp_val));
    if (exp_val != '0) chk("rd_data", 32'(rd_data_o), 32'(exp_data));
    if (cyc != 0) chk("busy", 32'(busy_o), 32'(exp_busy));
    if (use_want) chk("spec_grant", 32'(req_ready_o), 32'(want));
    g_addr = exp_addr;
    @(posedge clk);
    if (r) begin
      q.delete();
      rr = 0;
    end else begin
      foreach (q[n]) if (q[n].due != cyc) keep.push_back(q[n]);
      q = keep;
      if (w >= 0) begin
        q.push_back('{eng: w, due: cyc + int'(L), addr: g_addr});
        rr = (w + 1) % int'(E);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, '0);
  endtask

  initial begin
    logic [E*AW-1:0] addrs;
    logic [E-1:0]    seq [6];
    addrs = {8'd8, 8'd4, 8'd0};
    rst_i = 1'b1; req_valid_i = '0; req_addr_i = '0;
    #1;

    // Reset held with every engine requesting
    for (int i = 0; i < 3; i++) step(1'b1, '1, addrs, 1'b1, '0);

    // Fairness and data routing, all engines valid
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 6; i++) step(1'b0, '1, addrs, 1'b1, seq[i]);
    idle(3);

    // Sparse requests and pointer wrap
    step(1'b0, 3'b100, addrs, 1'b1, 3'b100);
    step(1'b0, 3'b101, addrs, 1'b1, 3'b001);
    step(1'b0, 3'b101, addrs, 1'b1, 3'b100);
    idle(3);

    // Outstanding cap: single engine gets every other cycle
    seq = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000};
    for (int i = 0; i < 6; i++) step(1'b0, 3'b010, addrs, 1'b1, seq[i]);
    idle(3);

    // Mid-flight reset drops both reads
    step(1'b0, 3'b001, addrs, 1'b1, 3'b001);
    step(1'b0, 3'b010, addrs, 1'b1, 3'b010);
    step(1'b1, 3'b111, addrs, 1'b1, 3'b000);
    idle(3);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), E'($urandom), (E*AW)'($urandom), 1'b0, '0);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
